// File: rtl/tug_war_referee_if.sv
// Tug-of-war referee bus: player keys into the referee, display/score
// signals out of it.
//   key_l, key_r : player key levels, synchronous to clk
//   lights       : one-hot lit position, MSB is leftmost, zero while a win shows
//   score_l/_r   : rounds won per player
//   winner       : 10 left, 01 right, 00 none
//   play_again   : one-cycle restart pulse
//   match_over   : high while the match result is displayed
interface tug_war_referee_if #(
  parameter int NUM_LIGHTS = 9
);
  logic                  key_l;
  logic                  key_r;
  logic [NUM_LIGHTS-1:0] lights;
  logic [2:0]            score_l;
  logic [2:0]            score_r;
  logic [1:0]            winner;
  logic                  play_again;
  logic                  match_over;

  // master: key source / display sink
  modport master (
    output key_l, key_r,
    input  lights, score_l, score_r, winner, play_again, match_over
  );

  // slave: the referee itself
  modport slave (
    input  key_l, key_r,
    output lights, score_l, score_r, winner, play_again, match_over
  );
endinterface

// File: rtl/tug_war_referee.sv
// Tug-of-war referee. Converts key rising edges into single-step moves of
// the lit position, detects a run-off at either end, keeps round scores,
// holds the win display for HOLD_CYCLES, then restarts with a one-cycle
// play_again pulse. After WIN_LIMIT round wins the match is frozen until
// both keys are held together.
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : tug_war_referee_if slave modport (keys in, display out)
//
// state      | meaning
// PLAY       | keys move the light; run-off ends the round
// WIN_HOLD   | win display held, counter running down
// MATCH_OVER | match result frozen until both keys pressed together
module tug_war_referee #(
  parameter int NUM_LIGHTS  = 9,
  parameter int HOLD_CYCLES = 8,
  parameter int WIN_LIMIT   = 7
) (
  input  logic               clk,
  input  logic               reset,
  tug_war_referee_if.slave   bus
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] POS_MAX  = PW'(NUM_LIGHTS - 1);
  localparam logic [PW-1:0] CENTER   = PW'(NUM_LIGHTS / 2);
  localparam logic [CW-1:0] CNT_INIT = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    LIMIT    = 3'(WIN_LIMIT);

  typedef enum logic [1:0] {PLAY, WIN_HOLD, MATCH_OVER} state_t;

  state_t                state;
  logic [PW-1:0]         pos;
  logic [CW-1:0]         cnt;
  logic                  key_l_q, key_r_q;
  logic [NUM_LIGHTS-1:0] lights;
  logic [2:0]            score_l, score_r;
  logic [1:0]            winner;
  logic                  play_again, match_over;
  logic                  press_l, press_r;

  function automatic logic [NUM_LIGHTS-1:0] onehot(input logic [PW-1:0] p);
    onehot = {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << p;
  endfunction

  assign press_l = bus.key_l & ~key_l_q;
  assign press_r = bus.key_r & ~key_r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PLAY;
      pos        <= CENTER;
      lights     <= onehot(CENTER);
      cnt        <= '0;
      key_l_q    <= 1'b0;
      key_r_q    <= 1'b0;
      score_l    <= 3'd0;
      score_r    <= 3'd0;
      winner     <= 2'b00;
      play_again <= 1'b0;
      match_over <= 1'b0;
    end else begin
      key_l_q    <= bus.key_l;
      key_r_q    <= bus.key_r;
      play_again <= 1'b0;
      case (state)
        PLAY: begin
          if (press_l && !press_r) begin
            if (pos == POS_MAX) begin
              score_l <= score_l + 3'd1;
              winner  <= 2'b10;
              lights  <= '0;
              cnt     <= CNT_INIT;
              state   <= WIN_HOLD;
            end else begin
              pos    <= pos + 1'b1;
              lights <= onehot(pos + 1'b1);
            end
          end else if (press_r && !press_l) begin
            if (pos == '0) begin
              score_r <= score_r + 3'd1;
              winner  <= 2'b01;
              lights  <= '0;
              cnt     <= CNT_INIT;
              state   <= WIN_HOLD;
            end else begin
              pos    <= pos - 1'b1;
              lights <= onehot(pos - 1'b1);
            end
          end
        end
        WIN_HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if ((winner == 2'b10 && score_l == LIMIT) ||
                       (winner == 2'b01 && score_r == LIMIT)) begin
            state      <= MATCH_OVER;
            match_over <= 1'b1;
          end else begin
            state      <= PLAY;
            pos        <= CENTER;
            lights     <= onehot(CENTER);
            winner     <= 2'b00;
            play_again <= 1'b1;
          end
        end
        MATCH_OVER: begin
          // exit on levels, not presses: both keys simply held together
          if (bus.key_l && bus.key_r) begin
            state      <= PLAY;
            pos        <= CENTER;
            lights     <= onehot(CENTER);
            score_l    <= 3'd0;
            score_r    <= 3'd0;
            winner     <= 2'b00;
            match_over <= 1'b0;
            play_again <= 1'b1;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

  assign bus.lights     = lights;
  assign bus.score_l    = score_l;
  assign bus.score_r    = score_r;
  assign bus.winner     = winner;
  assign bus.play_again = play_again;
  assign bus.match_over = match_over;

endmodule

// File: doc/tug_war_referee.md
Name: tug_war_referee

Overview:
- Game controller for the tug-of-war light bar.
- Turns the two player keys into single-step moves of the lit position, and detects when the light runs off either end.
- Keeps per-player round scores, holds a win display for a fixed time, then issues a one-cycle play_again pulse to restart the bar.
- Sits between the key synchronizers and the LED/score display logic.

Parameters:
NUM_LIGHTS, 9, number of bar positions; must be odd and at least 3; center index C = NUM_LIGHTS/2
HOLD_CYCLES, 8, clock cycles the win display is held before restart; at least 1
WIN_LIMIT, 7, round wins needed to win the match; 1..7

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
key_l  in  1  left player key, level, already synchronous to clk
key_r  in  1  right player key, level, already synchronous to clk
lights  out  NUM_LIGHTS  one-hot lit position; bit NUM_LIGHTS-1 is leftmost; all-zero while a win is shown
score_l  out  3  left rounds won, 0..WIN_LIMIT
score_r  out  3  right rounds won, 0..WIN_LIMIT
winner  out  2  00 none, 10 left won round, 01 right won round; 11 never driven
play_again  out  1  one-cycle restart pulse
match_over  out  1  high while in MATCH_OVER

Behaviour:
- Reset (reset=0, asynchronous, effective immediately at any time):
  - state=PLAY, pos=C, lights=one-hot C
  - score_l=score_r=0, winner=00, play_again=0, match_over=0
  - hold counter=0, key history registers=0
- All outputs are registered.
- Press detection:
  - press_l = key_l & ~key_l_q; press_r likewise.
  - History registers update every cycle in every state.
  - A held key produces exactly one press.
  - A key held through a restart does not produce a new press.
- PLAY:
  - press_l & press_r in the same cycle: no move.
  - press_l only, pos<NUM_LIGHTS-1: pos+1 at next edge.
  - press_l only, pos=NUM_LIGHTS-1: left wins the round.
    - score_l+1, winner=10, lights=0, hold counter=HOLD_CYCLES-1, go to WIN_HOLD.
  - press_r mirrors press_l: pos-1 when pos>0; at pos=0 right wins (score_r+1, winner=01).
  - No press: hold state.
- WIN_HOLD:
  - Presses are ignored.
  - Counter decrements each edge while nonzero.
  - On the edge where the counter=0:
    - If the winner's score = WIN_LIMIT: go to MATCH_OVER; winner and scores held, lights stay 0, match_over=1.
    - Otherwise: go to PLAY with pos=C, winner=00, play_again=1 for exactly that next cycle.
  - Timing: the win edge is edge k. lights=one-hot C and play_again=1 appear after edge k+HOLD_CYCLES. play_again returns to 0 after edge k+HOLD_CYCLES+1.
- MATCH_OVER:
  - Presses are ignored.
  - Leaves only when key_l=1 and key_r=1 (levels) in the same cycle.
  - On exit: scores=0, winner=00, pos=C, match_over=0, play_again=1 for one cycle, state=PLAY.
- Score arithmetic:
  - 3-bit unsigned counters.
  - Increment only on a round win.
  - Never exceed WIN_LIMIT (guaranteed by the MATCH_OVER transition).
  - No wrap.
- Reset mid-WIN_HOLD or mid-MATCH_OVER: reset state as above; no play_again pulse is emitted.

Test Plan:
- Reset then idle 5 cycles -> lights=9'b000010000, scores 0, winner 00, play_again 0.
- Four single-cycle key_l pulses, then one key_r pulse -> lights steps 000100000, 001000000, 010000000, 100000000, then 010000000; no winner.
- key_l held high 6 cycles -> exactly one step (000100000); simultaneous key_l/key_r rising edge -> no move.
- Drive pos to 0 with key_r pulses, then one more key_r pulse (edge k) -> after edge k: lights=0, winner=01, score_r=1. play_again=1 and lights=000010000 only after edge k+8. Key presses during the hold have no effect.
- WIN_LIMIT=2 override: left wins two rounds -> after the second hold, match_over=1, winner=10, score_l=2, no play_again pulse, key_l alone ignored. Then key_l=key_r=1 for one cycle -> scores 0, match_over 0, one-cycle play_again, lights center.
- Assert reset low mid-WIN_HOLD (counter=3) -> outputs return to reset values asynchronously, before the next clk edge; no play_again pulse after release.
